// File: rtl/microsequencer_engine_if.sv
// Bus between the microsequencer engine and its surroundings: run control,
// halt/resume, microword control fields, flags, and the sequencer outputs.
// Modports:
//   master - the environment: drives run control, microword fields and
//            flags, and observes the sequencer outputs.
//   slave  - the engine itself.
// Clock and reset are kept outside the interface as plain module ports.
interface microsequencer_engine_if #(
  parameter int UADDR_WIDTH = 16,
  parameter int FLAG_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SEL_W = $clog2(FLAG_WIDTH);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic                   enable;
  logic                   halt;
  logic                   resume;
  logic [UADDR_WIDTH-1:0] entry_address;
  logic                   control_finish;
  logic                   control_return;
  logic                   control_call;
  logic                   control_branch;
  logic [SEL_W-1:0]       cond_select;
  logic                   cond_invert;
  logic [UADDR_WIDTH-1:0] branch_target;
  logic [FLAG_WIDTH-1:0]  flags;

  logic [UADDR_WIDTH-1:0] micro_address;
  logic                   microcode_rom_read_enable;
  logic                   program_counter_enable;
  logic                   fetch_strobe;
  logic                   halted;
  logic                   error;
  logic [1:0]             error_code;
  logic [LVL_W-1:0]       stack_level;
  logic [2:0]             state;

  modport master (
    output enable, halt, resume, entry_address,
    output control_finish, control_return, control_call, control_branch,
    output cond_select, cond_invert, branch_target, flags,
    input  micro_address, microcode_rom_read_enable, program_counter_enable,
    input  fetch_strobe, halted, error, error_code, stack_level, state
  );

  modport slave (
    input  enable, halt, resume, entry_address,
    input  control_finish, control_return, control_call, control_branch,
    input  cond_select, cond_invert, branch_target, flags,
    output micro_address, microcode_rom_read_enable, program_counter_enable,
    output fetch_strobe, halted, error, error_code, stack_level, state
  );
endinterface

// File: rtl/microsequencer_engine.sv
// Microsequencer engine: sequences instruction fetch, opcode entry load and
// microword stepping, with flag-conditional micro-branches, a micro-call
// return stack and a resumable halt state.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - microsequencer_engine_if.slave (run control, microword fields,
//             flags in; micro_address, strobes, status and debug state out)
// Handshake: there is no valid/ready pairing here; every input is a level
// sampled on a rising clock edge while enable is high, and enable low freezes
// all registered state while the level outputs keep following the state.
module microsequencer_engine #(
  parameter int UADDR_WIDTH = 16,
  parameter int FLAG_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  microsequencer_engine_if.slave bus
);
  localparam int SEL_W = $clog2(FLAG_WIDTH);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int EXT_W = 1 << SEL_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALTED  = 3'd4,
    ERROR   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [UADDR_WIDTH-1:0] uaddr_q, uaddr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [1:0]             code_q, code_d;
  logic [UADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic                   push_en;
  logic [UADDR_WIDTH-1:0] uaddr_inc;
  logic [EXT_W-1:0]       flags_ext;
  logic                   cond_true;
  logic [IDX_W-1:0]       top_idx;
  logic [IDX_W-1:0]       push_idx;

  assign uaddr_inc = uaddr_q + UADDR_WIDTH'(1);
  // Zero-extending the flags makes any out-of-range select read as 0.
  assign flags_ext = EXT_W'(bus.flags);
  assign cond_true = flags_ext[bus.cond_select] ^ bus.cond_invert;
  assign top_idx   = IDX_W'(level_q - LVL_W'(1));
  assign push_idx  = IDX_W'(level_q);

  always_comb begin
    state_d = state_q;
    uaddr_d = uaddr_q;
    level_d = level_q;
    code_d  = code_q;
    push_en = 1'b0;
    if (bus.enable) begin
      case (state_q)
        IDLE:   state_d = FETCH;
        FETCH:  state_d = DECODE;
        DECODE: begin
          if (bus.halt) begin
            state_d = HALTED;
          end else begin
            uaddr_d = bus.entry_address;
            level_d = '0;
            state_d = EXECUTE;
          end
        end
        EXECUTE: begin
          if (bus.control_finish) begin
            level_d = '0;
            state_d = FETCH;
          end else if (bus.control_return) begin
            if (level_q == '0) begin
              state_d = ERROR;
              code_d  = 2'b10;
            end else begin
              uaddr_d = stack_q[top_idx];
              level_d = level_q - LVL_W'(1);
            end
          end else if (bus.control_call) begin
            if (level_q == LVL_W'(STACK_DEPTH)) begin
              state_d = ERROR;
              code_d  = 2'b01;
            end else begin
              push_en = 1'b1;
              uaddr_d = bus.branch_target;
              level_d = level_q + LVL_W'(1);
            end
          end else if (bus.control_branch) begin
            uaddr_d = cond_true ? bus.branch_target : uaddr_inc;
          end else begin
            uaddr_d = uaddr_inc;
          end
        end
        HALTED: if (bus.resume) state_d = FETCH;
        ERROR:  state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      uaddr_q <= '0;
      level_q <= '0;
      code_q  <= 2'b00;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
      level_q <= level_d;
      code_q  <= code_d;
      if (push_en) stack_q[push_idx] <= uaddr_inc;
    end
  end

  // The PC strobe is gated by state and enable so an abort or stall can never
  // leave a partial increment behind.
  assign bus.program_counter_enable = bus.enable &&
      (((state_q == EXECUTE) && bus.control_finish) ||
       ((state_q == HALTED) && bus.resume));
  assign bus.microcode_rom_read_enable = (state_q == EXECUTE);
  assign bus.fetch_strobe  = (state_q == FETCH);
  assign bus.halted        = (state_q == HALTED);
  assign bus.error         = (state_q == ERROR);
  assign bus.error_code    = code_q;
  assign bus.micro_address = uaddr_q;
  assign bus.stack_level   = level_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_microsequencer_engine.sv
module tb_microsequencer_engine;
  localparam int UW = 16;
  localparam int FW = 8;
  localparam int SD = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  microsequencer_engine_if #(.UADDR_WIDTH(UW), .FLAG_WIDTH(FW), .STACK_DEPTH(SD)) bus ();

  microsequencer_engine #(.UADDR_WIDTH(UW), .FLAG_WIDTH(FW), .STACK_DEPTH(SD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mw(input logic fin, input logic ret, input logic cal, input logic br,
                    input logic [UW-1:0] tgt);
    bus.control_finish = fin;
    bus.control_return = ret;
    bus.control_call   = cal;
    bus.control_branch = br;
    bus.branch_target  = tgt;
  endtask

  // Checks the per-cycle view: state, address, PC strobe, fetch strobe.
  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [UW-1:0] ma,
                              input logic pce, input logic fs);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".uaddr"}, 32'(bus.micro_address), 32'(ma));
    check({tag, ".pc_en"}, 32'(bus.program_counter_enable), 32'(pce));
    check({tag, ".fetch"}, 32'(bus.fetch_strobe), 32'(fs));
  endtask

  task automatic expect_reset(input string tag);
    expect_cycle(tag, 3'd0, 16'h0000, 1'b0, 1'b0);
    check({tag, ".level"}, 32'(bus.stack_level), 32'd0);
    check({tag, ".error"}, 32'(bus.error), 32'd0);
    check({tag, ".code"}, 32'(bus.error_code), 32'd0);
    check({tag, ".halted"}, 32'(bus.halted), 32'd0);
    check({tag, ".rom_re"}, 32'(bus.microcode_rom_read_enable), 32'd0);
  endtask

  initial begin
    bus.enable = 1'b0; bus.halt = 1'b0; bus.resume = 1'b0;
    bus.entry_address = '0; bus.flags = '0; bus.cond_select = '0; bus.cond_invert = 1'b0;
    mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset state
    #2;
    expect_reset("reset");
    #1;
    reset_n = 1'b1;
    bus.enable = 1'b1;
    bus.entry_address = 16'h0010;
    #1;
    expect_cycle("idle", 3'd0, 16'h0000, 1'b0, 1'b0);

    // Sequential instruction: 0x10, 0x11, 0x12 with finish on the third
    step(); #1; expect_cycle("seq_fetch", 3'd1, 16'h0000, 1'b0, 1'b1);
    step(); #1; expect_cycle("seq_decode", 3'd2, 16'h0000, 1'b0, 1'b0);
    step(); #1; expect_cycle("seq_u0", 3'd3, 16'h0010, 1'b0, 1'b0);
    check("seq_u0.rom_re", 32'(bus.microcode_rom_read_enable), 32'd1);
    step(); #1; expect_cycle("seq_u1", 3'd3, 16'h0011, 1'b0, 1'b0);
    step(); mw(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("seq_u2", 3'd3, 16'h0012, 1'b1, 1'b0);
    step(); mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); bus.entry_address = 16'h0040; #1;
    expect_cycle("seq_refetch", 3'd1, 16'h0012, 1'b0, 1'b1);

    // Conditional branches with flags = 0x04
    step(); #1; expect_cycle("br_decode", 3'd2, 16'h0012, 1'b0, 1'b0);
    step(); bus.flags = 8'h04; bus.cond_select = 3'd2; bus.cond_invert = 1'b0;
    mw(1'b0, 1'b0, 1'b0, 1'b1, 16'h0030); #1;
    expect_cycle("br_u0", 3'd3, 16'h0040, 1'b0, 1'b0);
    step(); bus.cond_invert = 1'b1; mw(1'b0, 1'b0, 1'b0, 1'b1, 16'h0050); #1;
    expect_cycle("br_taken", 3'd3, 16'h0030, 1'b0, 1'b0);
    step(); bus.cond_select = 3'd1; bus.cond_invert = 1'b0; #1;
    expect_cycle("br_inv_not_taken", 3'd3, 16'h0031, 1'b0, 1'b0);
    step(); bus.cond_invert = 1'b1; mw(1'b0, 1'b0, 1'b0, 1'b1, 16'h0060); #1;
    expect_cycle("br_clear_not_taken", 3'd3, 16'h0032, 1'b0, 1'b0);
    step(); mw(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("br_inv_taken", 3'd3, 16'h0060, 1'b1, 1'b0);

    // Address wrap from all-ones to zero
    step(); mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); bus.entry_address = 16'hFFFF; #1;
    expect_cycle("wrap_fetch", 3'd1, 16'h0060, 1'b0, 1'b1);
    step(); step(); #1; expect_cycle("wrap_u0", 3'd3, 16'hFFFF, 1'b0, 1'b0);
    step(); mw(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("wrap_u1", 3'd3, 16'h0000, 1'b1, 1'b0);
    check("wrap.error", 32'(bus.error), 32'd0);

    // Halt then resume
    step(); mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); bus.halt = 1'b1; #1;
    expect_cycle("halt_fetch", 3'd1, 16'h0000, 1'b0, 1'b1);
    step(); #1; expect_cycle("halt_decode", 3'd2, 16'h0000, 1'b0, 1'b0);
    step(); bus.halt = 1'b0; #1;
    expect_cycle("halted", 3'd4, 16'h0000, 1'b0, 1'b0);
    check("halted.flag", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 9; i++) begin
      step(); #1;
      check("halt_hold.state", 32'(bus.state), 32'd4);
      check("halt_hold.pc_en", 32'(bus.program_counter_enable), 32'd0);
    end
    bus.resume = 1'b1; #1;
    check("resume.pc_en", 32'(bus.program_counter_enable), 32'd1);
    step(); bus.resume = 1'b0; bus.entry_address = 16'h0005; #1;
    expect_cycle("resume_fetch", 3'd1, 16'h0000, 1'b0, 1'b1);
    check("resume_fetch.halted", 32'(bus.halted), 32'd0);

    // Call/return with a two-entry stack, then overflow
    step(); #1;
    step(); mw(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020); #1;
    expect_cycle("call_u05", 3'd3, 16'h0005, 1'b0, 1'b0);
    step(); mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("call_u20", 3'd3, 16'h0020, 1'b0, 1'b0);
    check("call_u20.level", 32'(bus.stack_level), 32'd1);
    step(); mw(1'b0, 1'b0, 1'b1, 1'b0, 16'h0028); #1;
    expect_cycle("call_u21", 3'd3, 16'h0021, 1'b0, 1'b0);
    step(); mw(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("call_u28", 3'd3, 16'h0028, 1'b0, 1'b0);
    check("call_u28.level", 32'(bus.stack_level), 32'd2);
    step(); #1;
    expect_cycle("ret_u22", 3'd3, 16'h0022, 1'b0, 1'b0);
    check("ret_u22.level", 32'(bus.stack_level), 32'd1);
    step(); mw(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020); #1;
    expect_cycle("ret_u06", 3'd3, 16'h0006, 1'b0, 1'b0);
    check("ret_u06.level", 32'(bus.stack_level), 32'd0);
    step(); mw(1'b0, 1'b0, 1'b1, 1'b0, 16'h0028); #1;
    step(); mw(1'b0, 1'b0, 1'b1, 1'b0, 16'h0030); #1;
    check("full.level", 32'(bus.stack_level), 32'd2);
    step(); mw(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("ovf", 3'd5, 16'h0028, 1'b0, 1'b0);
    check("ovf.error", 32'(bus.error), 32'd1);
    check("ovf.code", 32'(bus.error_code), 32'd1);
    check("ovf.level", 32'(bus.stack_level), 32'd2);
    check("ovf.rom_re", 32'(bus.microcode_rom_read_enable), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      expect_cycle("ovf_sticky", 3'd5, 16'h0028, 1'b0, 1'b0);
      check("ovf_sticky.error", 32'(bus.error), 32'd1);
    end
    reset_n = 1'b0; #1;
    expect_reset("ovf_reset");

    // Underflow: return with empty stack
    mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); bus.entry_address = 16'h0070;
    reset_n = 1'b1;
    step(); step(); step(); mw(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("unf_u70", 3'd3, 16'h0070, 1'b0, 1'b0);
    step(); mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("unf", 3'd5, 16'h0070, 1'b0, 1'b0);
    check("unf.code", 32'(bus.error_code), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("unf_sticky.fetch", 32'(bus.fetch_strobe), 32'd0);
      check("unf_sticky.state", 32'(bus.state), 32'd5);
    end
    reset_n = 1'b0; #1;
    expect_reset("unf_reset");

    // Stall mid-EXECUTE, then asynchronous reset mid-cycle
    bus.entry_address = 16'h0010;
    reset_n = 1'b1;
    step(); step(); step(); step(); #1;
    expect_cycle("stall_u11", 3'd3, 16'h0011, 1'b0, 1'b0);
    bus.enable = 1'b0; mw(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); #1;
    expect_cycle("stall0", 3'd3, 16'h0011, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++) begin
      step(); #1;
      expect_cycle("stall", 3'd3, 16'h0011, 1'b0, 1'b0);
      check("stall.rom_re", 32'(bus.microcode_rom_read_enable), 32'd1);
    end
    bus.enable = 1'b1; mw(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(); #1;
    expect_cycle("stall_resume", 3'd3, 16'h0012, 1'b0, 1'b0);
    #2; reset_n = 1'b0; #1;
    expect_reset("async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/microsequencer_engine.md
# microsequencer_engine

Parametrised successor to the compute core's execution driver and microcode sequencer pair. It sequences instruction fetch, opcode-to-microcode entry load and microword stepping, and adds three things the previous driver lacked: flag-conditional micro-branches, a micro-subroutine call/return stack of configurable depth, and a resumable halt state. It sits between the program counter, program RAM, opcode translator ROM, microcode ROM and ALU flags, and replaces both the microcode sequencer counter and the execution driver.

## Interface

Parameters:
- UADDR_WIDTH, 16, width of the microcode address.
- FLAG_WIDTH, 8, width of the ALU flag vector.
- STACK_DEPTH, 4, number of micro-return entries (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run enable; low freezes all state.
- halt  in  1  halt request from the halt check, sampled in DECODE.
- resume  in  1  leave HALTED.
- entry_address  in  UADDR_WIDTH  microcode entry point from the opcode translator.
- control_finish  in  1  microword: last microword of this instruction.
- control_return  in  1  microword: pop the return address.
- control_call  in  1  microword: push uaddr+1 and jump to branch_target.
- control_branch  in  1  microword: conditional jump.
- cond_select  in  $clog2(FLAG_WIDTH)  flag index to test.
- cond_invert  in  1  invert the tested flag.
- branch_target  in  UADDR_WIDTH  jump and call target.
- flags  in  FLAG_WIDTH  ALU flags.
- micro_address  out  UADDR_WIDTH  microcode ROM address (registered).
- microcode_rom_read_enable  out  1  high in EXECUTE.
- program_counter_enable  out  1  PC increment strobe.
- fetch_strobe  out  1  high in FETCH.
- halted  out  1  high in HALTED.
- error  out  1  sticky error flag.
- error_code  out  2  01 = stack overflow, 10 = stack underflow, 00 = none.
- stack_level  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- state  out  3  encoded FSM state, for debug.

## Operation

- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALTED=4, ERROR=5.
- IDLE → FETCH when enable is high.
- FETCH lasts one cycle, then goes to DECODE. The synchronous program RAM read completes in this cycle.
- DECODE:
  - If halt is high, go to HALTED.
  - Otherwise load micro_address ← entry_address, clear the stack, and go to EXECUTE.
- EXECUTE evaluates the microword each enabled cycle. Priority: finish > return > call > branch > sequential.
  - finish: program_counter_enable=1 combinationally this cycle, clear the stack, go to FETCH.
  - return:
    - If stack_level==0, go to ERROR with code 10 and leave micro_address unchanged.
    - Otherwise micro_address ← top of stack and decrement the level.
  - call:
    - If stack_level==STACK_DEPTH, go to ERROR with code 01 and do not push.
    - Otherwise push micro_address+1 and set micro_address ← branch_target.
  - branch: if flags[cond_select]^cond_invert, micro_address ← branch_target; otherwise micro_address+1.
  - sequential: micro_address+1, modulo 2^UADDR_WIDTH. Wrap from all-ones to 0 is legal and not an error.
- HALTED:
  - If resume is high: program_counter_enable=1 for that cycle, then go to FETCH. This skips the halt instruction.
  - Otherwise hold.
- ERROR is sticky and all strobes are 0. Only reset_n exits it.
- enable low in any state:
  - no state transition, no stack or address update;
  - program_counter_enable=0;
  - the level outputs microcode_rom_read_enable, fetch_strobe and halted still reflect the current state.
- cond_select ≥ FLAG_WIDTH tests as 0.

## Timing

- Reset (asynchronous assert) drives:
  - state=IDLE, micro_address=0, stack_level=0;
  - error=0, error_code=00;
  - all strobes 0, halted=0.
- Outputs are combinational from state and inputs, except micro_address, the stack and error_code, which are registered.
- An instruction with N microwords (finish on the Nth) takes N+2 enabled cycles: FETCH, DECODE, then N EXECUTE.
- program_counter_enable is high in the last EXECUTE cycle, so the PC advances on the same edge that enters FETCH.
- The microcode ROM is asynchronous. control_* inputs are sampled in the same cycle micro_address is presented.
- Call and return each take one cycle: the target microword executes in the next cycle.
- reset_n asserted mid-instruction aborts immediately. There is no partial PC increment, because the strobe is combinational and gated by state.

## Test plan

- Sequential instruction: entry_address=0x0010, finish on the third microword. Expect:
  - micro_address 0x10, 0x11, 0x12;
  - program_counter_enable a single pulse at the 0x12 cycle;
  - fetch_strobe on the next cycle;
  - 5 cycles in total.
- Conditional branch: flags=0x04, cond_select=2. With cond_invert=0, expect a jump to 0x0030. With cond_invert=1, expect micro_address+1.
- Call/return with STACK_DEPTH=2: call from 0x05 to 0x20, nested call from 0x21 to 0x28. Expect:
  - stack_level=2;
  - return → 0x22, return → 0x06;
  - a third nested call → error=1, error_code=01, state=5, which persists until reset_n.
- Underflow: return with stack_level=0 → error_code=10 and no further fetch_strobe.
- Halt/resume: halt high in DECODE → halted=1 and no PC pulse. Hold for 10 cycles. A resume pulse gives one program_counter_enable, then FETCH.
- Stall and reset: enable low for 3 cycles mid-EXECUTE at micro_address 0x11 → 0x11 is held and no strobes fire. Then assert reset_n low asynchronously mid-cycle → all outputs reset immediately and state=0.
